// File: rtl/rubiks_pkg.sv
// Shared move encoding, ASCII constants and parser states for the cube-solver move queue.
package rubiks_pkg;

    typedef logic [2:0] face_t;
    typedef logic [1:0] mod_t;

    localparam face_t FACE_U = 3'd0;
    localparam face_t FACE_D = 3'd1;
    localparam face_t FACE_L = 3'd2;
    localparam face_t FACE_R = 3'd3;
    localparam face_t FACE_F = 3'd4;
    localparam face_t FACE_B = 3'd5;

    localparam mod_t MOD_HORARIO = 2'd0;
    localparam mod_t MOD_ANTI    = 2'd1;
    localparam mod_t MOD_DUPLO   = 2'd2;

    typedef struct packed {
        face_t face;
        mod_t  modif;
    } movimento_t;

    localparam logic [7:0] ASC_U       = 8'h55;
    localparam logic [7:0] ASC_D       = 8'h44;
    localparam logic [7:0] ASC_L       = 8'h4C;
    localparam logic [7:0] ASC_R       = 8'h52;
    localparam logic [7:0] ASC_F       = 8'h46;
    localparam logic [7:0] ASC_B       = 8'h42;
    localparam logic [7:0] ASC_APOST   = 8'h27;
    localparam logic [7:0] ASC_DOIS    = 8'h32;
    localparam logic [7:0] ASC_ESPACO  = 8'h20;
    localparam logic [7:0] ASC_LF      = 8'h0A;
    localparam logic [7:0] ASC_CR      = 8'h0D;

    typedef enum logic {
        ESPERA_FACE,
        ESPERA_MOD
    } estado_t;

    // Returns {is_face, face code}; is_face=0 for any non-face byte.
    function automatic logic [3:0] decodifica_face(input logic [7:0] b);
        case (b)
            ASC_U:   return {1'b1, FACE_U};
            ASC_D:   return {1'b1, FACE_D};
            ASC_L:   return {1'b1, FACE_L};
            ASC_R:   return {1'b1, FACE_R};
            ASC_F:   return {1'b1, FACE_F};
            ASC_B:   return {1'b1, FACE_B};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/fifo_sincrona.sv
// Generic first-word-fall-through FIFO with synchronous clear; head reads as zero when empty.
module fifo_sincrona #(
    parameter int unsigned LARGURA      = 5,
    parameter int unsigned PROFUNDIDADE = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            limpar,
    input  logic                            escrever,
    input  logic                            ler,
    input  logic [LARGURA-1:0]              dado_in,
    output logic [LARGURA-1:0]              dado_out,
    output logic                            valido,
    output logic                            cheio,
    output logic [$clog2(PROFUNDIDADE):0]   ocupacao
);
    localparam int unsigned AW = $clog2(PROFUNDIDADE);
    localparam logic [AW:0] MAX_CNT = (AW+1)'(PROFUNDIDADE);

    logic [LARGURA-1:0] mem_q [PROFUNDIDADE];
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        cnt_q;
    logic               push, pop;

    assign valido   = (cnt_q != '0);
    assign cheio    = (cnt_q == MAX_CNT);
    assign ocupacao = cnt_q;
    assign pop      = ler & valido;
    // A pop frees the slot the push needs, so a full FIFO still accepts.
    assign push     = escrever & (~cheio | pop);
    assign dado_out = valido ? mem_q[rd_q] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (limpar) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push && !limpar) mem_q[wr_q] <= dado_in;
    end

endmodule

// File: rtl/fila_movimentos.sv
// ASCII move parser feeding a FWFT move queue for the servo controller.
// Optional FILA_MOVIMENTOS_CONTADOR_EN adds the db_total pop counter output.
module fila_movimentos
    import rubiks_pkg::*;
#(
    parameter int unsigned PROFUNDIDADE = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            limpar,
    input  logic [7:0]                      rx_dado,
    input  logic                            rx_pronto,
    output logic [4:0]                      mov_dado,
    output logic                            mov_valido,
    input  logic                            mov_aceito,
    output logic [$clog2(PROFUNDIDADE):0]   ocupacao,
    output logic                            concluida,
    output logic                            erro_caractere,
    output logic                            erro_estouro
`ifdef FILA_MOVIMENTOS_CONTADOR_EN
    ,
    output logic [7:0]                      db_total
`endif
);
    estado_t    estado_q, estado_d;
    face_t      face_q, face_d;
    movimento_t mov_q, mov_d;
    logic       push_q, push_d;
    logic       armado_q, armado_d;
    logic       erro_car_q, erro_car_d;
    logic       erro_est_q;
    logic       cheio, pop_ef;
    logic [3:0] dec;
    logic       eh_face, eh_mod;
    mod_t       mod_byte;

    assign dec      = decodifica_face(rx_dado);
    assign eh_face  = dec[3];
    assign eh_mod   = (rx_dado == ASC_APOST) || (rx_dado == ASC_DOIS);
    assign mod_byte = (rx_dado == ASC_DOIS) ? MOD_DUPLO : MOD_ANTI;
    assign pop_ef   = mov_aceito & mov_valido;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= ESPERA_FACE;
            face_q     <= FACE_U;
            mov_q      <= '0;
            push_q     <= 1'b0;
            armado_q   <= 1'b0;
            erro_car_q <= 1'b0;
            erro_est_q <= 1'b0;
        end else if (limpar) begin
            estado_q   <= ESPERA_FACE;
            face_q     <= FACE_U;
            mov_q      <= '0;
            push_q     <= 1'b0;
            armado_q   <= 1'b0;
            erro_car_q <= 1'b0;
            erro_est_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            face_q     <= face_d;
            mov_q      <= mov_d;
            push_q     <= push_d;
            armado_q   <= armado_d;
            erro_car_q <= erro_car_d;
            erro_est_q <= erro_est_q | (push_q & cheio & ~pop_ef);
        end
    end

    always_comb begin
        estado_d = estado_q;
        if (rx_pronto) begin
            case (estado_q)
                ESPERA_FACE: if (eh_face) estado_d = ESPERA_MOD;
                ESPERA_MOD:  if (!eh_face && rx_dado != ASC_CR) estado_d = ESPERA_FACE;
                default:     estado_d = ESPERA_FACE;
            endcase
        end
    end

    always_comb begin
        face_d     = face_q;
        mov_d      = mov_q;
        push_d     = 1'b0;
        armado_d   = armado_q;
        erro_car_d = erro_car_q;
        if (rx_pronto) begin
            if (eh_face) begin
                face_d   = dec[2:0];
                armado_d = 1'b0;
            end
            case (estado_q)
                ESPERA_FACE: begin
                    if (rx_dado == ASC_LF) armado_d = 1'b1;
                    else if (!eh_face && rx_dado != ASC_ESPACO && rx_dado != ASC_CR)
                        erro_car_d = 1'b1;
                end
                ESPERA_MOD: begin
                    if (eh_mod) begin
                        push_d = 1'b1;
                        mov_d  = '{face: face_q, modif: mod_byte};
                    end else if (eh_face || rx_dado == ASC_ESPACO || rx_dado == ASC_LF) begin
                        push_d = 1'b1;
                        mov_d  = '{face: face_q, modif: MOD_HORARIO};
                        if (rx_dado == ASC_LF) armado_d = 1'b1;
                    end else if (rx_dado != ASC_CR) begin
                        erro_car_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    fifo_sincrona #(
        .LARGURA      ($bits(movimento_t)),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .limpar   (limpar),
        .escrever (push_q),
        .ler      (mov_aceito),
        .dado_in  (mov_q),
        .dado_out (mov_dado),
        .valido   (mov_valido),
        .cheio    (cheio),
        .ocupacao (ocupacao)
    );

    // The in-flight push must land before an armed sequence counts as drained.
    assign concluida      = armado_q & (ocupacao == '0) & ~push_q;
    assign erro_caractere = erro_car_q;
    assign erro_estouro   = erro_est_q;

`ifdef FILA_MOVIMENTOS_CONTADOR_EN
    logic [7:0] total_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      total_q <= '0;
        else if (limpar) total_q <= '0;
        else if (pop_ef) total_q <= total_q + 1'b1;
    end
    assign db_total = total_q;
`endif

endmodule

// File: tb/tb_fila_movimentos.sv
// Directed self-checking bench for fila_movimentos (depth 32).
module tb_fila_movimentos;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       limpar = 1'b0;
    logic [7:0] rx_dado = '0;
    logic       rx_pronto = 1'b0;
    logic [4:0] mov_dado;
    logic       mov_valido;
    logic       mov_aceito = 1'b0;
    logic [5:0] ocupacao;
    logic       concluida;
    logic       erro_caractere;
    logic       erro_estouro;
`ifdef FILA_MOVIMENTOS_CONTADOR_EN
    logic [7:0] db_total;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    fila_movimentos #(.PROFUNDIDADE(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .limpar         (limpar),
        .rx_dado        (rx_dado),
        .rx_pronto      (rx_pronto),
        .mov_dado       (mov_dado),
        .mov_valido     (mov_valido),
        .mov_aceito     (mov_aceito),
        .ocupacao       (ocupacao),
        .concluida      (concluida),
        .erro_caractere (erro_caractere),
        .erro_estouro   (erro_estouro)
`ifdef FILA_MOVIMENTOS_CONTADOR_EN
        ,
        .db_total       (db_total)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_dado   = b;
        rx_pronto = 1'b1;
        @(negedge clock);
        rx_pronto = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic pop_check(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, mov_dado}, {27'd0, exp});
        mov_aceito = 1'b1;
        @(negedge clock);
        mov_aceito = 1'b0;
    endtask

    task automatic clear();
        @(negedge clock);
        limpar = 1'b1;
        @(negedge clock);
        limpar = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_valido",   {31'd0, mov_valido},     0);
        check("rst_dado",     {27'd0, mov_dado},       0);
        check("rst_ocup",     {26'd0, ocupacao},       0);
        check("rst_concl",    {31'd0, concluida},      0);
        check("rst_ecar",     {31'd0, erro_caractere}, 0);
        check("rst_eest",     {31'd0, erro_estouro},   0);
        @(negedge clock);
        reset = 1'b1;

        // Basic sequence with modifiers
        send_str("R U' F2\n");
        settle();
        check("seq1_ocup",  {26'd0, ocupacao},  3);
        check("seq1_valid", {31'd0, mov_valido}, 1);
        check("seq1_concl_early", {31'd0, concluida}, 0);
        pop_check("seq1_m0", 5'h0C);
        pop_check("seq1_m1", 5'h01);
        pop_check("seq1_m2", 5'h12);
        check("seq1_ocup_end",  {26'd0, ocupacao},  0);
        check("seq1_concl",     {31'd0, concluida}, 1);

        // No separator between moves; next face clears concluida
        send_byte("R");
        check("seq2_concl_clr", {31'd0, concluida}, 0);
        send_str("U\n");
        settle();
        check("seq2_ocup", {26'd0, ocupacao}, 2);
        pop_check("seq2_m0", 5'h0C);
        pop_check("seq2_m1", 5'h00);
        check("seq2_ecar",  {31'd0, erro_caractere}, 0);
        check("seq2_concl", {31'd0, concluida}, 1);

        // Invalid byte discards pending face
        send_str("RX");
        settle();
        check("seq3_ecar", {31'd0, erro_caractere}, 1);
        check("seq3_ocup", {26'd0, ocupacao},       0);
        send_str("D\n");
        settle();
        check("seq3_ocup2", {26'd0, ocupacao}, 1);
        pop_check("seq3_m0", 5'h04);
        check("seq3_ecar_sticky", {31'd0, erro_caractere}, 1);
        clear();
        check("seq3_ecar_clr", {31'd0, erro_caractere}, 0);

        // Overflow without pop
        for (int i = 0; i < 33; i++) send_str("L ");
        settle();
        check("ovf_ocup", {26'd0, ocupacao},     32);
        check("ovf_eest", {31'd0, erro_estouro}, 1);
        check("ovf_head", {27'd0, mov_dado},     5'h08);
        // limpar wins over a simultaneous byte and pop
        @(negedge clock);
        limpar = 1'b1; mov_aceito = 1'b1; rx_pronto = 1'b1; rx_dado = "U";
        @(negedge clock);
        limpar = 1'b0; mov_aceito = 1'b0; rx_pronto = 1'b0;
        settle();
        check("clr_ocup",  {26'd0, ocupacao},     0);
        check("clr_eest",  {31'd0, erro_estouro}, 0);
        check("clr_valid", {31'd0, mov_valido},   0);

        // Push while full with a simultaneous pop
        for (int i = 0; i < 32; i++) send_str("L ");
        settle();
        check("full_ocup", {26'd0, ocupacao}, 32);
        send_byte("F");
        send_byte(" ");
        mov_aceito = 1'b1;
        @(negedge clock);
        mov_aceito = 1'b0;
        check("ovfpop_ocup", {26'd0, ocupacao},     32);
        check("ovfpop_eest", {31'd0, erro_estouro}, 0);
        for (int i = 0; i < 31; i++) begin
            mov_aceito = 1'b1;
            @(negedge clock);
        end
        mov_aceito = 1'b0;
        check("ovfpop_last", {27'd0, mov_dado}, 5'h10);
        check("ovfpop_ocup1", {26'd0, ocupacao}, 1);
        clear();

        // Asynchronous reset mid-sequence
        send_str("R U F D L B");
        settle();
        check("mid_ocup", {26'd0, ocupacao}, 5);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_ocup",  {26'd0, ocupacao},   0);
        check("arst_valid", {31'd0, mov_valido}, 0);
        check("arst_dado",  {27'd0, mov_dado},   0);
        @(negedge clock);
        reset = 1'b1;
        send_str("B2\n");
        settle();
        check("post_ocup", {26'd0, ocupacao}, 1);
        pop_check("post_m0", 5'h16);

`ifdef FILA_MOVIMENTOS_CONTADOR_EN
        clear();
        check("cnt_start", {24'd0, db_total}, 0);
        for (int i = 0; i < 256; i++) begin
            send_str("L ");
            settle();
            mov_aceito = 1'b1;
            @(negedge clock);
            mov_aceito = 1'b0;
            if (i == 254) check("cnt_255", {24'd0, db_total}, 255);
        end
        check("cnt_wrap", {24'd0, db_total}, 0);
        for (int i = 0; i < 3; i++) begin
            send_str("L ");
            settle();
            mov_aceito = 1'b1;
            @(negedge clock);
            mov_aceito = 1'b0;
        end
        check("cnt_3", {24'd0, db_total}, 3);
        clear();
        check("cnt_clr", {24'd0, db_total}, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
